// File: rtl/wb_seq_pkg.sv
// wb_seq_pkg: op, status and FSM encodings plus command-record width for wb_seq_master
package wb_seq_pkg;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_READ_CMP, OP_WAIT} op_e;
  typedef enum logic [1:0] {ST_OK, ST_ERR, ST_TIMEOUT, ST_MISMATCH} status_e;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_e;
  function automatic int cmd_w(input int aw, input int dw);
    return 2 + aw + 2 * dw + dw / 8;
  endfunction
endpackage

// File: rtl/wb_seq_fifo.sv
// wb_seq_fifo: command FIFO with wrap-bit pointers for full/empty detection
module wb_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wp, rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[PW-1:0]];
  // pointers advance on accepted push/pop; a push while full is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // storage needs no reset; pointers define validity
  always_ff @(posedge clk)
    if (push && !full) mem[wp[PW-1:0]] <= din;
endmodule

// File: rtl/wb_seq_master.sv
// wb_seq_master: Wishbone classic command sequencer; WB_SEQ_RETRY_EN enables rty_i reissue
module wb_seq_master
  import wb_seq_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW-1:0]   cmd_mask_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic [1:0]      rsp_status_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  output logic            busy_o,
  output logic            fail_o,
  output logic [7:0]      err_cnt_o
);
  localparam int SW = DW / 8;
  localparam int CW = cmd_w(AW, DW);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e          state, state_n;
  op_e             op;
  status_e         rsp_st, bus_st;
  logic [CW-1:0]   fifo_dout;
  logic            full, empty, pop, term, gap, retry, fail;
  logic [1:0]      f_op;
  logic [AW-1:0]   f_adr, adr;
  logic [DW-1:0]   f_dat, f_mask, dat, mask, rsp_dat;
  logic [SW-1:0]   f_sel, sel;
  logic [TW-1:0]   tmo;
  logic [15:0]     wcnt;
  logic [7:0]      err_cnt;
  wb_seq_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (cmd_valid_i),
    .pop   (pop),
    .din   ({cmd_op_i, cmd_adr_i, cmd_dat_i, cmd_mask_i, cmd_sel_i}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );
  assign {f_op, f_adr, f_dat, f_mask, f_sel} = fifo_dout;
  assign pop = (state == S_IDLE) && !empty;
`ifdef WB_SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] rcnt;
  assign retry = wb_rty_i && (rcnt < RW'(MAX_RETRY));
  // a retried attempt drops cyc for one cycle (gap) and counts against the budget
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      gap  <= 1'b0;
      rcnt <= '0;
    end else begin
      gap  <= (state == S_BUS) && !gap && retry;
      rcnt <= pop ? '0 : rcnt + RW'((state == S_BUS) && !gap && retry);
    end
`else
  assign gap   = 1'b0;
  assign retry = (MAX_RETRY < 0);
`endif
  assign term = (state == S_BUS) && !gap &&
                (wb_err_i || (wb_rty_i && !retry) || wb_ack_i || (tmo == TW'(TIMEOUT - 1)));
  assign bus_st = (wb_err_i || wb_rty_i) ? ST_ERR :
                  !wb_ack_i ? ST_TIMEOUT :
                  (op == OP_READ_CMP && ((wb_dat_i ^ dat) & mask) != '0) ? ST_MISMATCH : ST_OK;
  // next-state decode
  always_comb begin
    state_n = state;
    state_n = (state == S_IDLE) ? (empty ? S_IDLE : (f_op == 2'(OP_WAIT)) ? S_WAIT : S_BUS) :
              (state == S_BUS)  ? (term ? S_RESP : S_BUS) :
              (state == S_WAIT) ? ((wcnt == '0) ? S_RESP : S_WAIT) :
              (rsp_ready_i ? S_IDLE : S_RESP);
  end
  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) state <= S_IDLE;
    else state <= state_n;
  // command load, bus/wait timing, result capture and sticky error tracking
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      op      <= OP_WRITE;
      adr     <= '0;
      dat     <= '0;
      mask    <= '0;
      sel     <= '0;
      tmo     <= '0;
      wcnt    <= '0;
      rsp_dat <= '0;
      rsp_st  <= ST_OK;
      fail    <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (pop) begin
        op   <= op_e'(f_op);
        adr  <= f_adr;
        dat  <= f_dat;
        mask <= f_mask;
        sel  <= f_sel;
        tmo  <= '0;
        wcnt <= f_dat[15:0];
      end
      if (state == S_BUS) tmo <= (gap || retry) ? '0 : tmo + TW'(1);
      if (term) begin
        rsp_st  <= bus_st;
        rsp_dat <= (wb_ack_i && !wb_err_i && !wb_rty_i && op != OP_WRITE) ? wb_dat_i : '0;
      end
      if (state == S_WAIT) begin
        wcnt    <= wcnt - 16'd1;
        rsp_st  <= ST_OK;
        rsp_dat <= '0;
      end
      if (state == S_RESP && rsp_ready_i && rsp_st != ST_OK) begin
        fail    <= 1'b1;
        err_cnt <= err_cnt + 8'(err_cnt != 8'hff);
      end
    end
  assign cmd_ready_o  = !full;
  assign wb_cyc_o     = (state == S_BUS) && !gap;
  assign wb_stb_o     = wb_cyc_o;
  assign wb_we_o      = wb_cyc_o && (op == OP_WRITE);
  assign wb_adr_o     = adr;
  assign wb_dat_o     = dat;
  assign wb_sel_o     = sel;
  assign rsp_valid_o  = state == S_RESP;
  assign rsp_dat_o    = rsp_dat;
  assign rsp_status_o = rsp_st;
  assign busy_o       = !empty || (state != S_IDLE);
  assign fail_o       = fail;
  assign err_cnt_o    = err_cnt;
endmodule

// File: tb/tb_wb_seq_master.sv
// tb_wb_seq_master: directed self-checking bench for wb_seq_master with a scripted slave
module tb_wb_seq_master;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [1:0]  cmd_op = 0, rsp_status;
  logic [31:0] cmd_adr = 0, cmd_dat = 0, cmd_mask = 0, rsp_dat;
  logic [3:0]  cmd_sel = 0, wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_cyc, wb_stb, wb_we, busy, fail;
  logic [7:0]  err_cnt;
  int          checks = 0, failures = 0;
  int          mode = 0, rty_n = 0, att_base = 0, att_cnt = 0;
  logic [31:0] rdata = 0;
  logic        stb_q = 0, s_ack = 0, s_err = 0, s_rty = 0;
  logic [31:0] d;
  logic [1:0]  s;
  int          n;

  always #5 clk = ~clk;

  wb_seq_master dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_mask_i(cmd_mask), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_cyc_o(wb_cyc),
    .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_dat_i(wb_dat_i), .wb_ack_i(s_ack),
    .wb_err_i(s_err), .wb_rty_i(s_rty), .busy_o(busy), .fail_o(fail), .err_cnt_o(err_cnt)
  );

  assign wb_dat_i = (mode == 3) ? (wb_adr ^ 32'h5A00) : rdata;

  // slave: one wait state, then respond per mode (0/3 ack, 1 silent, 2 rty then ack, 4 err)
  always @(posedge clk) begin
    stb_q <= wb_stb;
    s_ack <= 0;
    s_err <= 0;
    s_rty <= 0;
    if (wb_stb && !stb_q) att_cnt <= att_cnt + 1;
    if (wb_stb && !s_ack && !s_err && !s_rty) begin
      if (mode == 0 || mode == 3) s_ack <= 1;
      else if (mode == 4) s_err <= 1;
      else if (mode == 2) begin
        if (att_cnt - att_base < rty_n) s_rty <= 1;
        else s_ack <= 1;
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] adr, dat, mask, input logic [3:0] sel);
    cmd_op = op; cmd_adr = adr; cmd_dat = dat; cmd_mask = mask; cmd_sel = sel; cmd_valid = 1;
    for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL push_accept got ready=%0b want 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] dd, output logic [1:0] ss, output int nn);
    nn = 0;
    while (!rsp_valid && nn < 1000) begin
      @(negedge clk);
      nn++;
    end
    dd = rsp_valid ? rsp_dat : 'x;
    ss = rsp_valid ? rsp_status : 'x;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, wb_cyc, wb_stb, wb_we, rsp_valid, busy, fail} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags got %b want 1000000", {cmd_ready, wb_cyc, wb_stb, wb_we, rsp_valid, busy, fail});
    end
    checks++;
    if ({err_cnt, wb_adr, wb_sel, rsp_dat, rsp_status} !== '0) begin
      failures++;
      $display("FAIL reset_values got cnt=%0h adr=%0h sel=%0h dat=%0h st=%0d want 0", err_cnt, wb_adr, wb_sel, rsp_dat, rsp_status);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write();
    mode = 0;
    push(2'd0, 32'h3, 32'h83, 32'h0, 4'h1);
    checks++;
    if (wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL write_latency_e0 got cyc=%0b want 0", wb_cyc);
    end
    @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o} !== {3'b111, 4'h1, 32'h3, 32'h83}) begin
      failures++;
      $display("FAIL write_bus got cyc=%0b stb=%0b we=%0b sel=%0h adr=%0h dat=%0h want 1 1 1 1 3 83", wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o);
    end
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd0, 32'h0}) begin
      failures++;
      $display("FAIL write_rsp got st=%0d dat=%0h want 0 0", s, d);
    end
    ack_rsp();
  endtask

  task automatic test_read_cmp();
    mode = 0;
    rdata = 32'h60;
    push(2'd2, 32'h5, 32'h60, 32'h60, 4'h1);
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd0, 32'h60}) begin
      failures++;
      $display("FAIL cmp_match got st=%0d dat=%0h want 0 60", s, d);
    end
    ack_rsp();
    rdata = 32'h20;
    push(2'd2, 32'h5, 32'h60, 32'h60, 4'h1);
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd3, 32'h20}) begin
      failures++;
      $display("FAIL cmp_mismatch got st=%0d dat=%0h want 3 20", s, d);
    end
    checks++;
    if ({fail, err_cnt} !== {1'b0, 8'd0}) begin
      failures++;
      $display("FAIL sticky_before_accept got fail=%0b cnt=%0d want 0 0", fail, err_cnt);
    end
    ack_rsp();
    checks++;
    if ({fail, err_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL sticky_after_accept got fail=%0b cnt=%0d want 1 1", fail, err_cnt);
    end
  endtask

  task automatic test_wait();
    push(2'd3, 32'h0, 32'd3, 32'h0, 4'h0);
    wait_rsp(d, s, n);
    checks++;
    if ({n, s, d} !== {32'd5, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL wait3 got cycles=%0d st=%0d dat=%0h want 5 0 0", n, s, d);
    end
    ack_rsp();
    push(2'd3, 32'h0, 32'd0, 32'h0, 4'h0);
    wait_rsp(d, s, n);
    checks++;
    if ({n, s, d} !== {32'd2, 2'd0, 32'h0}) begin
      failures++;
      $display("FAIL wait0 got cycles=%0d st=%0d dat=%0h want 2 0 0", n, s, d);
    end
    ack_rsp();
  endtask

  task automatic test_timeout();
    int cyc_n = 0;
    mode = 1;
    push(2'd1, 32'h7, 32'h0, 32'h0, 4'h1);
    for (int i = 0; i < 600 && !rsp_valid; i++) begin
      if (wb_cyc) cyc_n++;
      @(negedge clk);
    end
    checks++;
    if (cyc_n != 255) begin
      failures++;
      $display("FAIL timeout_cycles got %0d want 255", cyc_n);
    end
    wait_rsp(d, s, n);
    checks++;
    if (s !== 2'd2) begin
      failures++;
      $display("FAIL timeout_status got %0d want 2", s);
    end
    ack_rsp();
    checks++;
    if (err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL timeout_errcnt got %0d want 2", err_cnt);
    end
    mode = 0;
    rdata = 32'hA5;
    push(2'd1, 32'h9, 32'h0, 32'h0, 4'hF);
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd0, 32'hA5}) begin
      failures++;
      $display("FAIL after_timeout got st=%0d dat=%0h want 0 a5", s, d);
    end
    ack_rsp();
  endtask

  task automatic test_err();
    mode = 4;
    rdata = 32'hDEAD;
    push(2'd1, 32'hC, 32'h0, 32'h0, 4'hF);
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd1, 32'h0}) begin
      failures++;
      $display("FAIL err_rsp got st=%0d dat=%0h want 1 0", s, d);
    end
    ack_rsp();
    checks++;
    if (err_cnt !== 8'd3) begin
      failures++;
      $display("FAIL err_errcnt got %0d want 3", err_cnt);
    end
  endtask

  task automatic test_retry();
    int att, want_att;
    logic [1:0] want_st;
`ifdef WB_SEQ_RETRY_EN
    want_att = 3;
    want_st = 2'd0;
`else
    want_att = 1;
    want_st = 2'd1;
`endif
    mode = 2;
    rty_n = 2;
    att_base = att_cnt;
    push(2'd0, 32'h11, 32'h22, 32'h0, 4'hF);
    wait_rsp(d, s, n);
    att = att_cnt - att_base;
    checks++;
    if (att != want_att) begin
      failures++;
      $display("FAIL retry_attempts got %0d want %0d", att, want_att);
    end
    checks++;
    if (s !== want_st) begin
      failures++;
      $display("FAIL retry_status got %0d want %0d", s, want_st);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    logic drop = 0;
    logic [31:0] want;
    mode = 3;
    for (int i = 0; i < 9; i++) begin
      push(2'd1, 32'h10 + 32'(4 * i), 32'h0, 32'h0, 4'hF);
      if (i == 7) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_after_8 got %0b want 1", cmd_ready);
        end
      end
    end
    checks++;
    if ({cmd_ready, busy} !== 2'b01) begin
      failures++;
      $display("FAIL full_after_9 got ready=%0b busy=%0b want 0 1", cmd_ready, busy);
    end
    cmd_op = 2'd1; cmd_adr = 32'h10 + 32'd36; cmd_valid = 1;
    rsp_ready = 1;
    for (int c = 0; c < 600 && got < 10; c++) begin
      if (drop) cmd_valid = 0;
      drop = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        want = (32'h10 + 32'(4 * got)) ^ 32'h5A00;
        checks++;
        if ({rsp_status, rsp_dat} !== {2'd0, want}) begin
          failures++;
          $display("FAIL drain_%0d got st=%0d dat=%0h want 0 %0h", got, rsp_status, rsp_dat, want);
        end
        got++;
      end
      @(negedge clk);
    end
    rsp_ready = 0;
    cmd_valid = 0;
    checks++;
    if (got != 10) begin
      failures++;
      $display("FAIL drain_count got %0d want 10", got);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    push(2'd1, 32'h40, 32'h0, 32'h0, 4'hF);
    push(2'd1, 32'h44, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 10 && !wb_cyc; i++) @(negedge clk);
    checks++;
    if (wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL mid_cyc_up got %0b want 1", wb_cyc);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb} !== 2'b00) begin
      failures++;
      $display("FAIL async_drop got cyc=%0b stb=%0b want 0 0", wb_cyc, wb_stb);
    end
    checks++;
    if ({busy, fail, err_cnt, cmd_ready, rsp_valid} !== {1'b0, 1'b0, 8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_state got busy=%0b fail=%0b cnt=%0d ready=%0b rv=%0b want 0 0 0 1 0", busy, fail, err_cnt, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1;
    mode = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, wb_cyc} !== 2'b00) begin
      failures++;
      $display("FAIL fifo_flushed got busy=%0b cyc=%0b want 0 0", busy, wb_cyc);
    end
    push(2'd0, 32'h3, 32'h1, 32'h0, 4'h1);
    wait_rsp(d, s, n);
    checks++;
    if ({s, d} !== {2'd0, 32'h0}) begin
      failures++;
      $display("FAIL post_reset_write got st=%0d dat=%0h want 0 0", s, d);
    end
    ack_rsp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_cmp();
    test_wait();
    test_timeout();
    test_err();
    test_retry();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_seq_master.md
Name: wb_seq_master

Overview:
- Parametrised, synthesizable Wishbone classic master that executes queued bus commands and reports per-command results.
- Successor to the behavioural Wishbone master used in our SoC benches; generalised in address/data width and queue depth.
- Adds read-compare, timed waits, bus-timeout detection, retry handling and sticky pass/fail status.
- Sits between a stimulus source (bench thread or on-chip self-test controller) and a Wishbone slave such as uart_top.

Parameters:
- AW, 32, address width.
- DW, 32, data width; multiple of 8; SEL width is DW/8.
- DEPTH, 8, command FIFO entries; power of 2, at least 2.
- TIMEOUT, 255, maximum cycles cyc_o may stay high without a termination.
- MAX_RETRY, 3, maximum reissues on rty_i (only with the optional feature).

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command offer.
- cmd_ready_o  out  1  FIFO not full.
- cmd_op_i  in  2  operation: 0 WRITE, 1 READ, 2 READ_CMP, 3 WAIT.
- cmd_adr_i  in  AW  bus address.
- cmd_dat_i  in  DW  write data, compare data, or wait cycle count.
- cmd_mask_i  in  DW  compare mask.
- cmd_sel_i  in  DW/8  byte selects.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  result consumed.
- rsp_dat_o  out  DW  read data; 0 for WRITE and WAIT.
- rsp_status_o  out  2  result: 0 OK, 1 ERR, 2 TIMEOUT, 3 MISMATCH.
- wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o  out  AW/DW/DW/8/1/1/1  Wishbone master outputs.
- wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i  in  DW/1/1/1  Wishbone slave returns.
- busy_o  out  1  FIFO non-empty or FSM not in IDLE.
- fail_o  out  1  sticky; set by any non-OK status.
- err_cnt_o  out  8  count of non-OK results; saturates at 255.

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1. FIFO flushed; FSM to IDLE.
- Reset asserted mid-cycle: wb_cyc_o/wb_stb_o drop asynchronously and the pending response is lost.
- Command accept: cmd_valid_i && cmd_ready_o on an edge writes one FIFO entry.
- cmd_ready_o = !full. Push on full is ignored; no overwrite.
- FSM states: IDLE, BUS, WAIT, RESP.
- IDLE: if FIFO non-empty, pop at the edge and load the command.
  - WRITE/READ/READ_CMP: go to BUS with cyc/stb/adr/sel driven from the registered command; we=1 only for WRITE.
  - WAIT: go to WAIT with the counter loaded from cmd_dat_i[15:0].
  - Latency: a command accepted into an empty FIFO at edge E0 shows wb_cyc_o high after edge E1.
- BUS: cyc_o and stb_o held constant until one of the following is sampled. Priority: err_i > rty_i > ack_i > timeout.
  - ack_i: capture wb_dat_i for reads. READ_CMP reports MISMATCH if (wb_dat_i & mask) != (cmd_dat & mask), else OK.
  - err_i: status ERR.
  - rty_i: status ERR (feature-dependent; see Optional Feature).
  - Timeout: the cycle counter reaches TIMEOUT with no termination; status TIMEOUT. An ack_i on the same cycle as timeout wins.
  - On any termination, cyc_o/stb_o deassert at that edge and the FSM goes to RESP.
- WAIT: decrement each cycle; a count of 0 completes in 1 cycle; go to RESP with status OK.
- RESP: rsp_valid_o high with rsp_dat_o/rsp_status_o stable until rsp_ready_i. Returns to IDLE on that edge.
  - A new command may be popped on the following edge, giving at least one idle bus cycle between transfers.
- fail_o and err_cnt_o update at the edge where a non-OK response is accepted.
- fail_o and err_cnt_o clear only on reset.
- Results are returned strictly in command order; one outstanding bus transfer at a time.

Optional Feature:
- Macro: WB_SEQ_RETRY_EN.
- Defined: rty_i drops cyc/stb for one cycle, then reissues the identical transfer, up to MAX_RETRY times.
  - Each reissue restarts the timeout counter.
  - Exceeding MAX_RETRY gives status ERR.
- Undefined: rty_i is treated exactly as err_i, and no retry counter is present.

Decomposition:
- Package wb_seq_pkg:
  - op encodings (WRITE/READ/READ_CMP/WAIT);
  - status encodings (OK/ERR/TIMEOUT/MISMATCH);
  - FSM state encoding;
  - packed command-record width helper (2+AW+2*DW+DW/8).
- Sub-module wb_seq_fifo: synchronous FIFO with DEPTH entries of command-record width, full/empty flags, pointers one bit wider than log2(DEPTH).

Test Plan:
- WRITE adr 0x3, dat 0x83, sel 0x1 to uart_top:
  - wb_cyc_o high after E1, wb_we_o=1, wb_sel_o=0x1;
  - response OK, rsp_dat_o 0.
- READ_CMP adr 0x5, dat 0x60, mask 0x60 with slave returning 0x60, then 0x20:
  - first response OK;
  - second MISMATCH, fail_o=1, err_cnt_o=1.
- Slave that never acks, TIMEOUT=255:
  - cyc_o high for exactly 255 cycles;
  - status TIMEOUT; the next command proceeds normally.
- rty_i on the first two attempts, then ack:
  - with WB_SEQ_RETRY_EN: 3 bus attempts, status OK;
  - without it: 1 attempt, status ERR.
- Push 10 commands with DEPTH=8 while rsp_ready_i=0:
  - cmd_ready_o low after 8 accepted plus 1 in the FSM;
  - releasing rsp_ready_i drains all 10 responses in order.
- Reset asserted while cyc_o=1:
  - cyc_o/stb_o low within the same cycle;
  - FIFO empty, busy_o=0, fail_o=0, err_cnt_o=0.
